regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the RV64I core. It succeeds the single-write, two-read regfile with the following changes:
- configurable width, depth and read-port count;
- two write ports with fixed priority;
- registered reads;
- a sequenced bulk-clear engine that walks the array without stalling reset.

It sits between decode (read addresses) and writeback (two retire lanes).

Parameters:
XLEN, 64, data width of each register
NREGS, 32, number of architectural registers; entry 0 hardwired to zero; range 2..256
NRD, 2, number of read ports; range 1..4
AW, $clog2(NREGS), localparam, register address width

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
rd_en  input  NRD  per-port read enable
rd_addr  input  NRD*AW  read addresses; port k at bits [k*AW +: AW]
rd_data  output  NRD*XLEN  registered read data; port k at bits [k*XLEN +: XLEN]
wr_en  input  2  write enable, lanes 0 and 1
wr_addr  input  2*AW  write addresses; lane k at bits [k*AW +: AW]
wr_data  input  2*XLEN  write data; lane k at bits [k*XLEN +: XLEN]
clr_req  input  1  single-cycle pulse; starts a bulk clear
clr_busy  output  1  high while the clear sequence runs

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On a rst cycle all entries go to 0, rd_data goes to 0, clr_busy goes to 0 and the FSM goes to IDLE.
  - rst overrides every other input in the same cycle, including mid-clear.
- Entry 0:
  - Never stored; reads of address 0 return 0.
  - Writes to address 0 are dropped.
- Out-of-range address (addr >= NREGS, possible when NREGS is not a power of 2):
  - Write is dropped.
  - Read returns 0.
- Writes:
  - Commit at posedge when wr_en[k]=1 and the FSM is in IDLE.
  - If both lanes target the same address, lane 1 wins; lane 0's data is discarded.
- Reads (1-cycle latency):
  - rd_data[k] updates at posedge only when rd_en[k]=1; otherwise it holds its previous value.
  - A read sees array contents from before that edge's writes (read-old), unless bypass is enabled (see Optional Feature).
- Clear FSM, two states:
  - IDLE -> CLEAR on clr_req=1. The pointer loads 1 and clr_busy rises the next cycle.
  - CLEAR: each cycle writes 0 to entry ptr, then ptr++.
  - CLEAR -> IDLE after the cycle that clears entry NREGS-1. Total: NREGS-1 cycles of clr_busy=1.
  - While in CLEAR, wr_en is ignored (writes dropped; upstream must stall) and rd_data loads 0 for enabled ports.
  - clr_req while in CLEAR is ignored; the sequence does not restart.
  - clr_req in the same cycle as a write while in IDLE: the write commits, then the clear begins.
- No combinational path from any input to rd_data or clr_busy.

Optional Feature:
Macro REGFILE_MP_BYPASS_EN.
- Defined: write-to-read forwarding. If rd_en[k] and a committing write (IDLE state, nonzero, in-range) targets rd_addr[k] in the same cycle, rd_data[k] loads the write data. Lane 1 has priority over lane 0. Read-after-write latency is 0 cycles.
- Undefined: read-old semantics. Same-cycle readers get the prior value; the new value is visible one cycle later.

Decomposition:
- Package regfile_pkg holds:
  - constants XLEN_DEF=64 and NREGS_DEF=32;
  - typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;
  - function rf_valid_addr(addr, nregs).
- Sub-module regfile_clr_seq contains the FSM, pointer and clr_busy. It outputs clr_active, clr_we and clr_addr.
- The array, write arbitration and read ports stay in regfile_mp.

Test Plan:
- Reset and read-back:
  - Stimulus: rst 1 cycle; then write 0xDEAD_BEEF_0000_0001 to x5 via lane 0; next cycle read x5 and x0.
  - Required: x5 = 0xDEAD_BEEF_0000_0001, x0 = 0, after 1-cycle latency.
- x0 protection:
  - Stimulus: write 0xFFFF_FFFF_FFFF_FFFF to x0 on both lanes; then read x0.
  - Required: 0.
- Lane conflict:
  - Stimulus: same cycle, lane 0 writes x7=0x11 and lane 1 writes x7=0x22; then read x7.
  - Required: 0x22.
- Same-cycle RAW:
  - Stimulus: x9 holds 0xAA; write x9=0xBB and read x9 in the same cycle.
  - Required: 0xBB with REGFILE_MP_BYPASS_EN defined, 0xAA without. 0xBB one cycle later in both builds.
- Bulk clear:
  - Stimulus: fill x1..x31 with nonzero values; pulse clr_req.
  - Required: clr_busy high for exactly 31 cycles. Writes issued during busy are dropped. Afterwards all reads return 0.
- Reset mid-clear:
  - Stimulus: assert rst 10 cycles into a clear.
  - Required: clr_busy=0 the next cycle and all entries 0. A write to x3=0x5 two cycles later commits normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register file.
// Optional build macro used by regfile_mp: REGFILE_MP_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  // True when addr names a storable entry: not the hardwired-zero x0 and below nregs.
  function automatic logic rf_valid_addr(input logic [31:0] addr, input int nregs);
    return (addr != 32'd0) && (addr < $unsigned(nregs));
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer: walks entries 1..NREGS-1, one per cycle, after a clr_req pulse.
// clr_busy/clr_active are decoded straight from the state register.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req_i,
  output logic          clr_active_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          clr_busy_o
);

  localparam logic [AW-1:0] FIRST_PTR = AW'(1);
  localparam logic [AW-1:0] LAST_PTR  = AW'(NREGS - 1);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  // State and pointer registers; reset wins over everything, including a running clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: a request is only honoured from IDLE; the walk ends after the last entry.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      RF_IDLE: begin
        if (clr_req_i) begin
          state_d = RF_CLEAR;
          ptr_d   = FIRST_PTR;
        end else begin
          state_d = RF_IDLE;
          ptr_d   = '0;
        end
      end
      RF_CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          state_d = RF_IDLE;
          ptr_d   = '0;
        end else begin
          state_d = RF_CLEAR;
          ptr_d   = ptr_q + AW'(1);
        end
      end
      default: begin
        state_d = RF_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  assign clr_active_o = (state_q == RF_CLEAR);
  assign clr_we_o     = clr_active_o;
  assign clr_addr_o   = ptr_q;
  assign clr_busy_o   = clr_active_o;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two prioritised write lanes, NRD registered read ports,
// x0 hardwired to zero, sequenced bulk clear.
// Build macro REGFILE_MP_BYPASS_EN: forward same-cycle committing writes to readers.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      rd_en_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  input  logic [1:0]          wr_en_i,
  input  logic [2*AW-1:0]     wr_addr_i,
  input  logic [2*XLEN-1:0]   wr_data_i,
  input  logic                clr_req_i,
  output logic                clr_busy_o
);

  // Storage covers the full address space; entries >= NREGS and entry 0 are never written.
  localparam int NENT = 1 << AW;

  logic [XLEN-1:0]           mem_q [NENT];
  logic                      clr_active_s;
  logic                      clr_we_s;
  logic [AW-1:0]             clr_addr_s;
  logic [1:0]                wr_commit_s;
  logic [AW-1:0]             wr_addr_s [2];
  logic [XLEN-1:0]           wr_data_s [2];
  logic [AW-1:0]             rd_addr_s [NRD];
  logic [NRD-1:0][XLEN-1:0]  rd_data_d, rd_data_q;

  regfile_clr_seq #(
    .NREGS (NREGS)
  ) u_clr_seq (
    .clk          (clk),
    .rst          (rst),
    .clr_req_i    (clr_req_i),
    .clr_active_o (clr_active_s),
    .clr_we_o     (clr_we_s),
    .clr_addr_o   (clr_addr_s),
    .clr_busy_o   (clr_busy_o)
  );

  // Write lane decode: a lane commits only from IDLE and only to a storable address.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      wr_addr_s[k]   = wr_addr_i[k*AW +: AW];
      wr_data_s[k]   = wr_data_i[k*XLEN +: XLEN];
      wr_commit_s[k] = wr_en_i[k] & ~clr_active_s & rf_valid_addr(32'(wr_addr_s[k]), NREGS);
    end
  end

  // Array update: clear engine owns the array while active; lane 1 is applied last so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NENT; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_we_s) begin
      mem_q[clr_addr_s] <= '0;
    end else begin
      if (wr_commit_s[0]) begin
        mem_q[wr_addr_s[0]] <= wr_data_s[0];
      end
      if (wr_commit_s[1]) begin
        mem_q[wr_addr_s[1]] <= wr_data_s[1];
      end
    end
  end

  // Read-port next value: hold when disabled, zero while clearing or for x0/out-of-range.
  always_comb begin
    rd_data_d = rd_data_q;
    for (int k = 0; k < NRD; k++) begin
      rd_addr_s[k] = rd_addr_i[k*AW +: AW];
      if (!rd_en_i[k]) begin
        rd_data_d[k] = rd_data_q[k];
      end else if (clr_active_s) begin
        rd_data_d[k] = '0;
      end else if (!rf_valid_addr(32'(rd_addr_s[k]), NREGS)) begin
        rd_data_d[k] = '0;
`ifdef REGFILE_MP_BYPASS_EN
      end else if (wr_commit_s[1] && (wr_addr_s[1] == rd_addr_s[k])) begin
        rd_data_d[k] = wr_data_s[1];
      end else if (wr_commit_s[0] && (wr_addr_s[0] == rd_addr_s[k])) begin
        rd_data_d[k] = wr_data_s[0];
`endif
      end else begin
        rd_data_d[k] = mem_q[rd_addr_s[k]];
      end
    end
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp with a cycle-level reference model of the register file.
module tb_regfile_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [1:0]          wr_en;
  logic [2*AW-1:0]     wr_addr;
  logic [2*XLEN-1:0]   wr_data;
  logic                clr_req;
  logic                clr_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: architectural contents, expected read registers, clear cycles left.
  logic [63:0] m_mem [NREGS];
  logic [63:0] m_rd  [NRD];
  int          m_busy;

  regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .clr_req_i  (clr_req),
    .clr_busy_o (clr_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] port(input int k);
    return rd_data[k*XLEN +: XLEN];
  endfunction

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    else return 5'($urandom_range(0, 31));
  endfunction

  function automatic logic [63:0] rnd_data();
    return {$urandom(), $urandom()};
  endfunction

  // Drive one cycle of inputs, advance the model by the spec's rules, then sample after the edge.
  task automatic step(input logic r, input logic [1:0] we,
                      input logic [4:0] wa0, input logic [63:0] wd0,
                      input logic [4:0] wa1, input logic [63:0] wd1,
                      input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic creq);
    logic [4:0] ra [2];
    rst     = r;
    wr_en   = we;
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    rd_en   = re;
    rd_addr = {ra1, ra0};
    clr_req = creq;
    ra[0] = ra0;
    ra[1] = ra1;
    if (r) begin
      for (int i = 0; i < NREGS; i++) m_mem[i] = 64'd0;
      for (int k = 0; k < NRD; k++) m_rd[k] = 64'd0;
      m_busy = 0;
    end else if (m_busy > 0) begin
      for (int k = 0; k < NRD; k++) if (re[k]) m_rd[k] = 64'd0;
      m_busy = m_busy - 1;
    end else begin
      for (int k = 0; k < NRD; k++) begin
        if (re[k]) begin
          if (ra[k] == 5'd0) m_rd[k] = 64'd0;
`ifdef REGFILE_MP_BYPASS_EN
          else if (we[1] && wa1 == ra[k]) m_rd[k] = wd1;
          else if (we[0] && wa0 == ra[k]) m_rd[k] = wd0;
`endif
          else m_rd[k] = m_mem[ra[k]];
        end
      end
      if (we[0] && wa0 != 5'd0) m_mem[wa0] = wd0;
      if (we[1] && wa1 != 5'd0) m_mem[wa1] = wd1;
      if (creq) begin
        // The sequential walk is unobservable: reads give 0 and writes drop until it ends.
        for (int i = 0; i < NREGS; i++) m_mem[i] = 64'd0;
        m_busy = NREGS - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 2'b00, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    step(1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    for (int k = 0; k < NRD; k++) begin
      n_checks++;
      if (port(k) !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_rd port%0d got %h exp 0", k, port(k));
      end
    end
    n_checks++;
    if (clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b exp 0", clr_busy);
    end
    step(1'b0, 2'b01, 5'd5, 64'hDEAD_BEEF_0000_0001, 5'd0, 64'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    step(1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 2'b11, 5'd5, 5'd0, 1'b0);
    n_checks++;
    if (port(0) !== 64'hDEAD_BEEF_0000_0001) begin
      n_fail++;
      $display("FAIL readback_x5 got %h exp %h", port(0), 64'hDEAD_BEEF_0000_0001);
    end
    n_checks++;
    if (port(1) !== 64'd0) begin
      n_fail++;
      $display("FAIL readback_x0 got %h exp 0", port(1));
    end
  endtask

  task automatic test_x0();
    step(1'b0, 2'b11, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF,
         2'b00, 5'd0, 5'd0, 1'b0);
    step(1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 2'b11, 5'd0, 5'd0, 1'b0);
    for (int k = 0; k < NRD; k++) begin
      n_checks++;
      if (port(k) !== 64'd0) begin
        n_fail++;
        $display("FAIL x0_protect port%0d got %h exp 0", k, port(k));
      end
    end
  endtask

  task automatic test_lane_conflict();
    step(1'b0, 2'b11, 5'd7, 64'h11, 5'd7, 64'h22, 2'b00, 5'd0, 5'd0, 1'b0);
    step(1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 2'b01, 5'd7, 5'd0, 1'b0);
    n_checks++;
    if (port(0) !== 64'h22) begin
      n_fail++;
      $display("FAIL lane_conflict got %h exp %h", port(0), 64'h22);
    end
  endtask

  task automatic test_raw();
    logic [63:0] exp_same;
`ifdef REGFILE_MP_BYPASS_EN
    exp_same = 64'hBB;
`else
    exp_same = 64'hAA;
`endif
    step(1'b0, 2'b01, 5'd9, 64'hAA, 5'd0, 64'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    step(1'b0, 2'b01, 5'd9, 64'hBB, 5'd0, 64'd0, 2'b01, 5'd9, 5'd0, 1'b0);
    n_checks++;
    if (port(0) !== exp_same) begin
      n_fail++;
      $display("FAIL raw_same_cycle got %h exp %h", port(0), exp_same);
    end
    step(1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 2'b10, 5'd0, 5'd9, 1'b0);
    n_checks++;
    if (port(1) !== 64'hBB) begin
      n_fail++;
      $display("FAIL raw_next_cycle got %h exp %h", port(1), 64'hBB);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(1'b0, 2'($urandom_range(0, 3)), rnd_addr(), rnd_data(), rnd_addr(), rnd_data(),
           2'($urandom_range(0, 3)), rnd_addr(), rnd_addr(), 1'b0);
      for (int k = 0; k < NRD; k++) begin
        n_checks++;
        if (port(k) !== m_rd[k]) begin
          n_fail++;
          $display("FAIL random c%0d port%0d got %h exp %h", c, k, port(k), m_rd[k]);
        end
      end
    end
  endtask

  task automatic test_bulk_clear();
    int cnt;
    for (int i = 1; i < NREGS; i += 2) begin
      step(1'b0, (i + 1 < NREGS) ? 2'b11 : 2'b01, 5'(i), rnd_data() | 64'd1,
           5'(i + 1), rnd_data() | 64'd1, 2'b00, 5'd0, 5'd0, 1'b0);
    end
    step(1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 2'b00, 5'd0, 5'd0, 1'b1);
    cnt = 0;
    while (clr_busy === 1'b1 && cnt < 100) begin
      cnt++;
      step(1'b0, 2'b11, rnd_addr(), rnd_data(), rnd_addr(), rnd_data(),
           2'b11, rnd_addr(), rnd_addr(), (cnt == 5) ? 1'b1 : 1'b0);
      for (int k = 0; k < NRD; k++) begin
        n_checks++;
        if (port(k) !== m_rd[k]) begin
          n_fail++;
          $display("FAIL clear_rd cyc%0d port%0d got %h exp %h", cnt, k, port(k), m_rd[k]);
        end
      end
    end
    n_checks++;
    if (cnt != NREGS - 1) begin
      n_fail++;
      $display("FAIL clear_busy_len got %0d exp %0d", cnt, NREGS - 1);
    end
    for (int i = 1; i < NREGS; i++) begin
      step(1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 2'b11, 5'(i), 5'(NREGS - i), 1'b0);
      for (int k = 0; k < NRD; k++) begin
        n_checks++;
        if (port(k) !== 64'd0) begin
          n_fail++;
          $display("FAIL clear_after x%0d port%0d got %h exp 0", i, k, port(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 2'b01, 5'(i), rnd_data() | 64'd1, 5'd0, 64'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    end
    step(1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 2'b00, 5'd0, 5'd0, 1'b1);
    for (int c = 0; c < 9; c++) idle();
    n_checks++;
    if (clr_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midclear_busy got %b exp 1", clr_busy);
    end
    step(1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    n_checks++;
    if (clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midclear_rst_busy got %b exp 0", clr_busy);
    end
    idle();
    step(1'b0, 2'b01, 5'd3, 64'h5, 5'd0, 64'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    step(1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 2'b01, 5'd3, 5'd0, 1'b0);
    n_checks++;
    if (port(0) !== 64'h5) begin
      n_fail++;
      $display("FAIL midclear_write_x3 got %h exp %h", port(0), 64'h5);
    end
    for (int i = 1; i < NREGS; i++) begin
      step(1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 2'b10, 5'd0, 5'(i), 1'b0);
      n_checks++;
      if (port(1) !== m_rd[1]) begin
        n_fail++;
        $display("FAIL midclear_sweep x%0d got %h exp %h", i, port(1), m_rd[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_lane_conflict();
    test_raw();
    test_random();
    test_bulk_clear();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
